// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding and index-width helper for the FIFO read arbiter
// Contents:
//   arbState_e  - arbiter FSM state (ST_IDLE, ST_BURST)
//   idxWidth()  - width of an index into n items, never less than 1
package fifo_arb_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arbState_e;
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_read_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector searching upward from the slot after lastIdx
// Ports:
//   req      in   N   request vector (bit i set = FIFO i has data)
//   lastIdx  in   IW  index granted last; search starts at lastIdx+1 (mod N)
//   found    out  1   some request is set
//   idx      out  IW  first requester found
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lastIdx,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(lastIdx) + k) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(lastIdx) + k) % N);
      end
    end
  end
endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter: round-robin burst arbiter sharing one valid/ready consumer among NUM_FIFOS FIFO read ports
// Build option: FIFO_ARB_STRICT_PRIO_EN selects lowest-index-first arbitration instead of round-robin.
// Ports:
//   readClkIn      in   1                     read-domain clock
//   readRstIn      in   1                     synchronous active-high reset
//   fifoEmptyIn    in   NUM_FIFOS             registered per-FIFO empty flags
//   fifoDataIn     in   NUM_FIFOS*DATA_WIDTH  flat read data, FIFO i at [i*DATA_WIDTH +: DATA_WIDTH]
//   readEnableOut  out  NUM_FIFOS             one-hot-or-zero read enable
//   dataOut        out  DATA_WIDTH            head of the output buffer
//   dataSrcOut     out  IDX_W                 FIFO index that produced dataOut
//   dataValidOut   out  1                     dataOut valid
//   dataReadyIn    in   1                     consumer accepts on valid & ready
//   busyOut        out  1                     in a burst or with a read in flight
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  localparam int IDX_W     = idxWidth(NUM_FIFOS)
) (
  input  logic                            readClkIn,
  input  logic                            readRstIn,
  input  logic [NUM_FIFOS-1:0]            fifoEmptyIn,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifoDataIn,
  output logic [NUM_FIFOS-1:0]            readEnableOut,
  output logic [DATA_WIDTH-1:0]           dataOut,
  output logic [IDX_W-1:0]                dataSrcOut,
  output logic                            dataValidOut,
  input  logic                            dataReadyIn,
  output logic                            busyOut
);
  arbState_e             state;
  logic [IDX_W-1:0]      grantIdx;
  logic [IDX_W-1:0]      inFlightIdx;
  logic [IDX_W-1:0]      pickIdx;
  logic                  pickFound;
  logic                  inFlight;
  logic [7:0]            beatCnt;
  logic [1:0]            bufOcc;
  logic [DATA_WIDTH-1:0] bufData [2];
  logic [IDX_W-1:0]      bufSrc [2];
  logic                  pop;
  logic                  space;
  logic                  issue;
  logic                  burstEnd;
  logic                  wrSel;
  logic [DATA_WIDTH-1:0] pushData;
`ifdef FIFO_ARB_STRICT_PRIO_EN
  // Scan downward so the lowest non-empty index is the last one written.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    for (int i = NUM_FIFOS - 1; i >= 0; i--) begin
      if (!fifoEmptyIn[i]) begin
        pickFound = 1'b1;
        pickIdx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rrPtr;
  rr_pick #(
    .N  (NUM_FIFOS),
    .IW (IDX_W)
  ) uPick (
    .req     (~fifoEmptyIn),
    .lastIdx (rrPtr),
    .found   (pickFound),
    .idx     (pickIdx)
  );
  always_ff @(posedge readClkIn) begin
    if (readRstIn) rrPtr <= IDX_W'(NUM_FIFOS - 1);
    else if (burstEnd) rrPtr <= grantIdx;
  end
`endif
  // Space counts the word already in flight so the 2-entry buffer can never overflow,
  // while a same-cycle pop still frees a slot for back-to-back reads.
  always_comb begin
    pop           = dataValidOut & dataReadyIn;
    space         = ({1'b0, bufOcc} + {2'b0, inFlight} - {2'b0, pop}) < 3'd2;
    issue         = (state == ST_BURST) & ~fifoEmptyIn[grantIdx] & space;
    burstEnd      = (state == ST_BURST) & ((issue & (beatCnt == 8'(BURST_LEN - 1))) | fifoEmptyIn[grantIdx]);
    readEnableOut = issue ? (NUM_FIFOS'(1) << grantIdx) : '0;
    wrSel         = (bufOcc - {1'b0, pop}) != 2'd0;
    pushData      = fifoDataIn[int'(inFlightIdx) * DATA_WIDTH +: DATA_WIDTH];
  end
  assign dataOut      = bufData[0];
  assign dataSrcOut   = bufSrc[0];
  assign dataValidOut = bufOcc != 2'd0;
  assign busyOut      = (state == ST_BURST) | inFlight;
  always_ff @(posedge readClkIn) begin
    if (readRstIn) begin
      state    <= ST_IDLE;
      grantIdx <= '0;
      beatCnt  <= '0;
    end else if (state == ST_IDLE) begin
      if (pickFound) begin
        state    <= ST_BURST;
        grantIdx <= pickIdx;
        beatCnt  <= '0;
      end
    end else begin
      if (issue) beatCnt <= beatCnt + 8'd1;
      if (burstEnd) state <= ST_IDLE;
    end
  end
  // Entry 0 is the head; a pop shifts entry 1 down and a push lands in the first
  // free slot after that shift (the later non-blocking write wins).
  always_ff @(posedge readClkIn) begin
    if (readRstIn) begin
      inFlight    <= 1'b0;
      inFlightIdx <= '0;
      bufOcc      <= '0;
      bufData     <= '{default: '0};
      bufSrc      <= '{default: '0};
    end else begin
      inFlight    <= issue;
      inFlightIdx <= grantIdx;
      if (pop) begin
        bufData[0] <= bufData[1];
        bufSrc[0]  <= bufSrc[1];
      end
      if (inFlight) begin
        bufData[wrSel] <= pushData;
        bufSrc[wrSel]  <= inFlightIdx;
      end
      bufOcc <= bufOcc + {1'b0, inFlight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// tb_fifo_read_arbiter: scoreboard bench driving four modelled 1-cycle-latency FIFOs into the arbiter
module tb_fifo_read_arbiter;
  localparam int NF = 4;
  localparam int DW = 8;
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ready = 1'b0;
  logic [NF-1:0]   empty;
  logic [NF-1:0]   ren;
  logic [NF*DW-1:0] fdata;
  logic [DW-1:0]   dout;
  logic [1:0]      dsrc;
  logic            dvalid;
  logic            busy;
  always #5 clk = ~clk;
  fifo_read_arbiter #(
    .NUM_FIFOS  (NF),
    .DATA_WIDTH (DW),
    .BURST_LEN  (4)
  ) dut (
    .readClkIn     (clk),
    .readRstIn     (rst),
    .fifoEmptyIn   (empty),
    .fifoDataIn    (fdata),
    .readEnableOut (ren),
    .dataOut       (dout),
    .dataSrcOut    (dsrc),
    .dataValidOut  (dvalid),
    .dataReadyIn   (ready),
    .busyOut       (busy)
  );
  logic [7:0] mem [NF][32];
  logic [4:0] wrP [NF] = '{default: '0};
  logic [4:0] rdP [NF] = '{default: '0};
  logic [7:0] dreg [NF] = '{default: '0};
  always @(posedge clk) begin
    for (int k = 0; k < NF; k++) begin
      if (ren[k]) begin
        dreg[k] <= mem[k][rdP[k]];
        rdP[k]  <= rdP[k] + 5'd1;
      end
    end
  end
  always_comb begin
    empty = '0;
    fdata = '0;
    for (int k = 0; k < NF; k++) begin
      empty[k] = wrP[k] == rdP[k];
      fdata[k*DW +: DW] = dreg[k];
    end
  end
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int popCnt = 0;
  int lastPopCyc = 0;
  int rdCnt [NF] = '{default: 0};
  logic [9:0] expQ [$];
  logic [9:0] expW;
  logic       holdV = 1'b0;
  logic [9:0] holdW = '0;
  always @(negedge clk) begin
    cyc++;
    checks++;
    if (!$onehot0(ren) || (ren & empty) != '0) begin
      errors++;
      $display("FAIL renLegal ren=%b empty=%b", ren, empty);
    end
    for (int k = 0; k < NF; k++) if (ren[k]) rdCnt[k]++;
    if (holdV && dvalid) begin
      checks++;
      if ({dsrc, dout} != holdW) begin
        errors++;
        $display("FAIL holdStable got=%h want=%h", {dsrc, dout}, holdW);
      end
    end
    if (dvalid && ready) begin
      popCnt++;
      lastPopCyc = cyc;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpectedWord got=%h want=none", {dsrc, dout});
      end else begin
        expW = expQ.pop_front();
        if ({dsrc, dout} != expW) begin
          errors++;
          $display("FAIL word got src=%0d data=%h want src=%0d data=%h", dsrc, dout, expW[9:8], expW[7:0]);
        end
      end
    end
    holdV = dvalid & ~ready;
    holdW = {dsrc, dout};
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, req);
    end
  endtask
  task automatic load(input int f, input int base, input int n);
    for (int j = 0; j < n; j++) begin
      mem[f][wrP[f]] = 8'(f * 16 + base + j);
      wrP[f] = wrP[f] + 5'd1;
    end
  endtask
  task automatic expectW(input int f, input int base, input int n);
    for (int j = 0; j < n; j++) expQ.push_back({2'(f), 8'(f * 16 + base + j)});
  endtask
  task automatic drain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || busy || dvalid) && n < 300) begin
      tick();
      n++;
    end
    check({name, "Left"}, expQ.size(), 0);
    check({name, "Done"}, int'(n < 300), 1);
  endtask
  initial begin
    int n;
    int start;
    int firstCyc;
    int r;
    int rd;
    rst = 1'b1;
    ready = 1'b0;
    tick();
    tick();
    check("rstRen", int'(ren), 0);
    check("rstValid", int'(dvalid), 0);
    check("rstData", int'(dout), 0);
    check("rstSrc", int'(dsrc), 0);
    check("rstBusy", int'(busy), 0);
    rst = 1'b0;
    repeat (20) begin
      tick();
      check("idleRen", int'(ren), 0);
      check("idleBusy", int'(busy), 0);
    end
`ifdef FIFO_ARB_STRICT_PRIO_EN
    ready = 1'b1;
    load(0, 0, 12);
    load(3, 0, 4);
    expectW(0, 0, 12);
    expectW(3, 0, 4);
    drain("strict");
`else
    ready = 1'b1;
    for (int f = 0; f < NF; f++) load(f, 0, 8);
    for (int b = 0; b < 2; b++) for (int f = 0; f < NF; f++) expectW(f, b * 4, 4);
    start = popCnt;
    n = 0;
    while (popCnt == start && n < 50) begin
      tick();
      n++;
    end
    firstCyc = lastPopCyc;
    check("rrStart", int'(n < 50), 1);
    drain("rr");
    check("rrSpan", lastPopCyc - firstCyc + 1, 39);
    r = rdCnt[2];
    load(2, 8, 2);
    load(3, 8, 3);
    expectW(2, 8, 2);
    expectW(3, 8, 3);
    drain("early");
    check("earlyReads", rdCnt[2] - r, 2);
    ready = 1'b0;
    r = rdCnt[1];
    load(1, 8, 4);
    expectW(1, 8, 4);
    repeat (5) tick();
    check("bpReads", rdCnt[1] - r, 2);
    check("bpValid", int'(dvalid), 1);
    check("bpData", int'(dout), 8'h18);
    check("bpSrc", int'(dsrc), 1);
    ready = 1'b1;
    drain("bp");
    check("bpTotal", rdCnt[1] - r, 4);
    load(0, 8, 6);
    expectW(0, 8, 1);
    n = 0;
    rd = 0;
    while (rd < 3 && n < 50) begin
      tick();
      n++;
      if (ren[0]) rd++;
    end
    check("rstThirdRead", rd, 3);
    rst = 1'b1;
    load(2, 12, 2);
    tick();
    check("midRstRen", int'(ren), 0);
    check("midRstValid", int'(dvalid), 0);
    check("midRstBusy", int'(busy), 0);
    rst = 1'b0;
    expectW(0, 11, 3);
    expectW(2, 12, 2);
    drain("midRst");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
